// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - tile sequencer for the NxN systolic MAC array (clear, skewed feed, drain, row writeback)
module systolic_ctrl #(
    parameter int  N   = 4,
    parameter int  K_W = 8,
    localparam int R_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,     // async, active low
    input  logic           start,       // begin a tile, honoured only in IDLE
    input  logic [K_W-1:0] k_len,       // reduction steps for the tile
    output logic           busy,
    output logic           err,         // start with k_len == 0
    output logic           mac_clear,
    output logic           rd_en,
    output logic [K_W-1:0] rd_addr,
    output logic [N-1:0]   feed_valid,  // per-row skewed operand valid
    input  logic [N-1:0]   mac_done,    // per-row completion pulses
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] out_row,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [K_W-1:0] rd_addr_q, rd_addr_d;
    logic [R_W-1:0] out_row_q, out_row_d;
    logic [N-1:0]   done_seen_q, done_seen_d;
    logic [N-1:0]   feed_valid_q, feed_valid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           mac_clear_q, mac_clear_d;
    logic           rd_en_q, rd_en_d;
    logic           out_valid_q, out_valid_d;
    logic           done_q, done_d;
    logic [N-1:0]   seen_now;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        err_d       = 1'b0;
        done_seen_d = done_seen_q;
        // rows completing this very cycle count toward the drain exit
        seen_now    = done_seen_q | mac_done;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = k_len;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                done_seen_d = '0;
                state_d     = S_FEED;
            end
            S_FEED: begin
                done_seen_d = seen_now;
                if (rd_addr_q == k_q - K_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                done_seen_d = seen_now;
                if (&seen_now) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_ready && out_row_q == R_W'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered copies decoded from the next state
        busy_d      = (state_d != S_IDLE);
        mac_clear_d = (state_d == S_CLEAR);
        rd_en_d     = (state_d == S_FEED);
        out_valid_d = (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);

        // rd_addr doubles as the step counter; it restarts on entry to FEED
        rd_addr_d = rd_addr_q;
        if (state_d == S_FEED) begin
            rd_addr_d = (state_q == S_FEED) ? rd_addr_q + K_W'(1) : '0;
        end

        out_row_d = '0;
        if (state_d == S_WRITE && state_q == S_WRITE) begin
            out_row_d = out_ready ? out_row_q + R_W'(1) : out_row_q;
        end

        // rd_en_q is low outside FEED, so zeros follow the last step down the chain
        feed_valid_d = {feed_valid_q[N-2:0], rd_en_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            rd_addr_q    <= '0;
            out_row_q    <= '0;
            done_seen_q  <= '0;
            feed_valid_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            mac_clear_q  <= 1'b0;
            rd_en_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            rd_addr_q    <= rd_addr_d;
            out_row_q    <= out_row_d;
            done_seen_q  <= done_seen_d;
            feed_valid_q <= feed_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            mac_clear_q  <= mac_clear_d;
            rd_en_q      <= rd_en_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign err        = err_q;
    assign mac_clear  = mac_clear_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign feed_valid = feed_valid_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl against a cycle-timeline model
module tb_systolic_ctrl;

    localparam int N   = 4;
    localparam int K_W = 8;
    localparam int R_W = 2;
    localparam int T   = 2500;

    logic           clk = 1'b1;
    logic           reset_n;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy;
    logic           err;
    logic           mac_clear;
    logic           rd_en;
    logic [K_W-1:0] rd_addr;
    logic [N-1:0]   feed_valid;
    logic [N-1:0]   mac_done;
    logic           out_valid;
    logic           out_ready;
    logic [R_W-1:0] out_row;
    logic           done;

    systolic_ctrl #(.N(N), .K_W(K_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .err        (err),
        .mac_clear  (mac_clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .feed_valid (feed_valid),
        .mac_done   (mac_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .done       (done)
    );

    always #5 clk = ~clk;

    // stimulus per cycle
    bit             st_rst   [T];
    bit             st_start [T];
    logic [K_W-1:0] st_k     [T];
    logic [N-1:0]   st_md    [T];
    bit             st_rdy   [T];

    // expected outputs per cycle
    bit             e_busy [T];
    bit             e_err  [T];
    bit             e_clr  [T];
    bit             e_rden [T];
    bit             e_ov   [T];
    bit             e_done [T];
    logic [K_W-1:0] e_addr [T];
    logic [N-1:0]   e_fv   [T];
    logic [R_W-1:0] e_row  [T];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    function automatic bit alive(input int x);
        return (x < T) && st_rst[x];
    endfunction

    // Walks the tile timeline with absolute cycle arithmetic:
    // start at t0, clear t0+1, feed t0+2..t0+K+1, drain from t0+K+2,
    // write from the cycle after all rows have reported, done after row N-1 is taken.
    task automatic build_model();
        int       c, x, t0, kk, r, w, done_at, last_addr, y;
        bit       err_next;
        logic [N-1:0] seen;
        for (int i = 0; i < T; i++) begin
            e_busy[i] = 0; e_err[i] = 0; e_clr[i] = 0; e_rden[i] = 0;
            e_ov[i] = 0; e_done[i] = 0; e_addr[i] = '0; e_fv[i] = '0; e_row[i] = '0;
        end
        last_addr = 0;
        err_next  = 0;
        c = 0;
        while (c < T) begin
            if (!st_rst[c]) begin
                last_addr = 0;
                err_next  = 0;
                c++;
                continue;
            end
            e_addr[c] = K_W'(last_addr);
            e_err[c]  = err_next;
            err_next  = 0;
            if (!st_start[c]) begin
                c++;
                continue;
            end
            if (st_k[c] == 0) begin
                err_next = 1;
                c++;
                continue;
            end
            t0 = c;
            kk = int'(st_k[c]);
            seen = '0;
            w = -1;
            r = 0;
            done_at = -1;
            x = t0 + 1;
            while (alive(x)) begin
                e_busy[x] = 1;
                if (x == t0 + 1) begin
                    e_clr[x] = 1;
                end else if (x <= t0 + 1 + kk) begin
                    e_rden[x] = 1;
                    last_addr = x - (t0 + 2);
                end
                e_addr[x] = K_W'(last_addr);
                if (x >= t0 + 2 && w < 0) begin
                    seen |= st_md[x];
                    if (x >= t0 + kk + 2 && seen == {N{1'b1}}) w = x + 1;
                end
                if (done_at > 0 && x == done_at) begin
                    e_done[x] = 1;
                    x++;
                    break;
                end
                if (w > 0 && x >= w) begin
                    e_ov[x]  = 1;
                    e_row[x] = R_W'(r);
                    if (st_rdy[x]) begin
                        r++;
                        if (r == N) done_at = x + 1;
                    end
                end
                x++;
            end
            // skew chain contents survive only until the tile ends or reset hits
            for (int j = 0; j < kk; j++) begin
                for (int i = 0; i < N; i++) begin
                    y = t0 + 3 + i + j;
                    if (y < x) e_fv[y][i] = 1'b1;
                end
            end
            c = x;
        end
    endtask

    task automatic apply(input int c);
        reset_n   = st_rst[c];
        start     = st_start[c];
        k_len     = st_k[c];
        mac_done  = st_md[c];
        out_ready = st_rdy[c];
    endtask

    task automatic check_cycle(input int c);
        chk("busy",       c, 32'(busy),       32'(e_busy[c]));
        chk("err",        c, 32'(err),        32'(e_err[c]));
        chk("mac_clear",  c, 32'(mac_clear),  32'(e_clr[c]));
        chk("rd_en",      c, 32'(rd_en),      32'(e_rden[c]));
        chk("rd_addr",    c, 32'(rd_addr),    32'(e_addr[c]));
        chk("feed_valid", c, 32'(feed_valid), 32'(e_fv[c]));
        chk("out_valid",  c, 32'(out_valid),  32'(e_ov[c]));
        chk("out_row",    c, 32'(out_row),    32'(e_row[c]));
        chk("done",       c, 32'(done),       32'(e_done[c]));
    endtask

    initial begin
        for (int c = 0; c < T; c++) begin
            st_rst[c] = 1; st_start[c] = 0; st_k[c] = '0; st_md[c] = '0; st_rdy[c] = 1;
        end
        // reset held with start high
        for (int c = 0; c < 3; c++) begin
            st_rst[c] = 0; st_start[c] = 1; st_k[c] = 8'd3;
        end
        // reference tile K=3, rows report one per cycle
        st_start[10] = 1; st_k[10] = 8'd3;
        st_md[17] = 4'b0001; st_md[18] = 4'b0010; st_md[19] = 4'b0100; st_md[20] = 4'b1000;
        // K=0 rejected
        st_start[40] = 1; st_k[40] = 8'd0;
        // K=2 with ignored, repeated and simultaneous completions, ready toggling
        st_start[50] = 1; st_k[50] = 8'd2;
        st_md[50] = 4'b1111; st_md[51] = 4'b1111; st_md[52] = 4'b0010; st_md[53] = 4'b0010;
        st_md[54] = 4'b1111; st_md[56] = 4'b1111;
        st_rdy[56] = 0; st_rdy[57] = 0; st_rdy[59] = 0;
        // reset in the middle of FEED, then a clean K=2 tile
        st_start[80] = 1; st_k[80] = 8'd4; st_rst[83] = 0;
        st_start[90] = 1; st_k[90] = 8'd2; st_md[95] = 4'b1111;
        // back-to-back tiles at the minimum period, start while busy ignored
        st_start[101] = 1; st_k[101] = 8'd1; st_md[104] = 4'b1111;
        st_start[104] = 1; st_k[104] = 8'd0;
        st_start[110] = 1; st_k[110] = 8'd1; st_md[113] = 4'b1111;
        // randomized traffic
        for (int c = 130; c < T; c++) begin
            st_rst[c]   = ($urandom_range(0, 399) != 0);
            st_start[c] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)       st_k[c] = 8'd0;
            else if ($urandom_range(0, 40) == 0) st_k[c] = 8'd40;
            else                                 st_k[c] = K_W'($urandom_range(1, 6));
            for (int i = 0; i < N; i++) st_md[c][i] = ($urandom_range(0, 3) == 0);
            st_rdy[c] = ($urandom_range(0, 2) != 0);
        end

        build_model();

        // hand-computed points that pin the model
        chk("pin_reset_busy", 1,  32'(e_busy[1]),    32'd0);
        chk("pin_clear",      11, 32'(e_clr[11]),    32'd1);
        chk("pin_addr0",      12, 32'(e_addr[12]),   32'd0);
        chk("pin_addr1",      13, 32'(e_addr[13]),   32'd1);
        chk("pin_addr2",      14, 32'(e_addr[14]),   32'd2);
        chk("pin_fv3_lo",     15, 32'(e_fv[15][3]),  32'd0);
        chk("pin_fv3_on",     16, 32'(e_fv[16][3]),  32'd1);
        chk("pin_fv3_end",    18, 32'(e_fv[18][3]),  32'd1);
        chk("pin_fv3_off",    19, 32'(e_fv[19][3]),  32'd0);
        chk("pin_row0",       21, 32'(e_ov[21]),     32'd1);
        chk("pin_row3",       24, 32'(e_row[24]),    32'd3);
        chk("pin_done",       25, 32'(e_done[25]),   32'd1);
        chk("pin_idle",       26, 32'(e_busy[26]),   32'd0);
        chk("pin_err",        41, 32'(e_err[41]),    32'd1);
        chk("pin_err_busy",   41, 32'(e_busy[41]),   32'd0);
        chk("pin_hs_done",    62, 32'(e_done[62]),   32'd1);
        chk("pin_hs_row",     59, 32'(e_row[59]),    32'd2);
        chk("pin_abort",      84, 32'(e_busy[84]),   32'd0);
        chk("pin_after_rst",  100, 32'(e_done[100]), 32'd1);
        chk("pin_b2b_done",   109, 32'(e_done[109]), 32'd1);
        chk("pin_b2b_clear",  111, 32'(e_clr[111]),  32'd1);
        chk("pin_b2b_done2",  118, 32'(e_done[118]), 32'd1);

        fork
            begin
                apply(0);
                #11;
                for (int c = 1; c < T; c++) begin
                    apply(c);
                    #10;
                end
            end
            begin
                #5;
                for (int c = 0; c < T; c++) begin
                    check_cycle(c);
                    #10;
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
